lc3_fetch: RTL and testbench

//  - LC-3 instruction-fetch / PC unit. Holds the 16-bit program counter and presents it as the memory read address.
//  - Computes the next PC when the control FSM pulses fetch_start: sequential, conditional branch, or register jump.
//  - Sits between the control FSM / execute stage (opcode, offset, register, condition codes) and instruction memory.

---
 rtl/lc3_pkg.sv | 8 +
 rtl/lc3_next_pc.sv | 29 ++
 rtl/lc3_fetch.sv | 35 +++
 tb/tb_lc3_fetch.sv | 89 ++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared LC-3 opcode constants and word type.
package lc3_pkg;
  typedef logic [15:0] word_t;
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;
endpackage

// File: rtl/lc3_next_pc.sv
// lc3_next_pc: combinational next-PC select (sequential, BR, JMP/JSRR, TRAP).
// TRAP vectoring is enabled by defining FETCH_TRAP_EN; otherwise TRAP is sequential.
module lc3_next_pc
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [8:0] offset,
  input  word_t      base,
  input  logic [2:0] br_nzp,
  input  logic [2:0] result_nzp,
  input  word_t      pc,
  output word_t      next_pc
);
  word_t seq, br_target, trap_pc;
  logic  taken;
  assign seq       = pc + 16'd1;
  assign br_target = seq + {{7{offset[8]}}, offset};
  assign taken     = |(br_nzp & result_nzp);
`ifdef FETCH_TRAP_EN
  assign trap_pc = {8'h00, offset[7:0]};
`else
  assign trap_pc = seq;
`endif
  always_comb begin
    next_pc = (opcode == OP_BR)                        ? (taken ? br_target : seq) :
              (opcode == OP_JMP || opcode == OP_JSR)   ? base :
              (opcode == OP_TRAP)                      ? trap_pc : seq;
  end
endmodule

// File: rtl/lc3_fetch.sv
// lc3_fetch: LC-3 program counter, advanced on fetch_start (FETCH_TRAP_EN enables TRAP vectoring).
module lc3_fetch
  import lc3_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [3:0]  opCode_in,
  input  logic [8:0]  offset_in,
  input  logic [15:0] reg_in,
  input  logic [2:0]  br_nzp,
  input  logic [2:0]  result_nzp,
  output logic [15:0] addr_out,
  output logic        wea_out,
  output logic [15:0] pc
);
  word_t next_pc;
  lc3_next_pc u_next_pc (
    .opcode    (opCode_in),
    .offset    (offset_in),
    .base      (reg_in),
    .br_nzp    (br_nzp),
    .result_nzp(result_nzp),
    .pc        (pc),
    .next_pc   (next_pc)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else if (fetch_start) pc <= next_pc;
  end
  assign addr_out = pc;
  assign wea_out  = 1'b0;
endmodule

// File: tb/tb_lc3_fetch.sv
// tb_lc3_fetch: directed vectors for lc3_fetch with hand-computed expected PCs.
module tb_lc3_fetch;
  logic        clk = 0, rst = 0, fetch_start = 0, wea_out;
  logic [3:0]  opCode_in = 0;
  logic [8:0]  offset_in = 0;
  logic [15:0] reg_in = 0, addr_out, pc;
  logic [2:0]  br_nzp = 0, result_nzp = 0;
  int checks = 0, failures = 0;

  lc3_fetch dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .opCode_in(opCode_in),
    .offset_in(offset_in), .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp),
    .addr_out(addr_out), .wea_out(wea_out), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic fs, input logic [3:0] op, input logic [8:0] off,
                      input logic [15:0] r, input logic [2:0] bn, input logic [2:0] rn);
    @(negedge clk);
    fetch_start = fs; opCode_in = op; offset_in = off; reg_in = r; br_nzp = bn; result_nzp = rn;
    @(posedge clk);
    #1 fetch_start = 0;
  endtask

  initial begin
    rst = 1;
    repeat (5) @(posedge clk);
    #1 check("pc_in_reset", pc, 16'h0000);
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1;
    check("reset_pc", pc, 16'h0000);
    check("reset_addr", addr_out, 16'h0000);
    check("reset_wea", {15'd0, wea_out}, 16'h0000);

    step(1, 4'b1100, 9'h000, 16'h0010, 3'b000, 3'b000); check("jmp_0010", pc, 16'h0010);
    step(1, 4'b0000, 9'h005, 16'h0000, 3'b010, 3'b010); check("br_taken", pc, 16'h0016);
    step(1, 4'b0000, 9'h005, 16'h0000, 3'b100, 3'b001); check("br_not_taken", pc, 16'h0017);
    step(1, 4'b0000, 9'h1FF, 16'h0000, 3'b001, 3'b001); check("br_minus1", pc, 16'h0017);
    step(1, 4'b0000, 9'h005, 16'h0000, 3'b000, 3'b111); check("br_mask0", pc, 16'h0018);
    step(1, 4'b0000, 9'h005, 16'h0000, 3'b111, 3'b000); check("br_cc0", pc, 16'h0019);
    step(1, 4'b0000, 9'h100, 16'h0000, 3'b111, 3'b100); check("br_neg_wrap", pc, 16'hFF1A);

    step(1, 4'b1100, 9'h000, 16'h3000, 3'b000, 3'b000); check("jmp_3000", pc, 16'h3000);
    check("addr_eq_pc", addr_out, 16'h3000);
    step(0, 4'b1100, 9'h000, 16'h5000, 3'b000, 3'b000); check("hold", pc, 16'h3000);
    step(1, 4'b0100, 9'h000, 16'h4242, 3'b000, 3'b000); check("jsrr", pc, 16'h4242);

    step(1, 4'b1100, 9'h000, 16'hFFFF, 3'b000, 3'b000); check("jmp_ffff", pc, 16'hFFFF);
    step(1, 4'b0001, 9'h000, 16'h1234, 3'b111, 3'b111); check("wrap", pc, 16'h0000);

    step(1, 4'b1111, 9'h025, 16'h1234, 3'b000, 3'b000);
`ifdef FETCH_TRAP_EN
    check("trap", pc, 16'h0025);
`else
    check("trap", pc, 16'h0001);
`endif
    step(1, 4'b1100, 9'h000, 16'h0100, 3'b000, 3'b000);
    step(1, 4'b0011, 9'h1FF, 16'h9999, 3'b111, 3'b111); check("other_op", pc, 16'h0101);

    @(negedge clk);
    fetch_start = 1; opCode_in = 4'b0001;
    repeat (3) @(posedge clk);
    #1 fetch_start = 0;
    check("multi_fetch", pc, 16'h0104);
    check("wea_zero", {15'd0, wea_out}, 16'h0000);

    @(negedge clk);
    fetch_start = 1; opCode_in = 4'b1100; reg_in = 16'h5555; rst = 1;
    #1 check("async_reset", pc, 16'h0000);
    @(posedge clk);
    #1 check("reset_race", pc, 16'h0000);
    @(negedge clk) begin rst = 0; fetch_start = 0; end
    @(posedge clk);
    #1 check("post_race_hold", pc, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
